obuft_tx_sequencer: RTL



---
 rtl/obuft_tx_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/obuft_tx_sequencer.sv
// obuft_tx_sequencer: serialises words into an O_I/O_T pair for a tri-state
// output buffer, framing each burst as lead-in drive, data bits, tail drive.
//
// Ports:
//   CLK, RST_N              clock, async active-low reset
//   DIN, DIN_VALID          word to send and its valid strobe
//   DIN_READY               word accepted this cycle when DIN_VALID is high
//   ABORT                   ends the current burst via the tail phase
//   O_I, O_T                buffer data and tri-state control (1 = high-Z)
//   BUSY                    burst in progress
module obuft_tx_sequencer #(
  parameter int WIDTH     = 8,
  parameter int LEAD      = 2,
  parameter int TAIL      = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  input  logic             ABORT,
  output logic             O_I,
  output logic             O_T,
  output logic             BUSY
);

  localparam int LW = (LEAD > 1) ? $clog2(LEAD) : 1;
  localparam int WW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int TW = (TAIL > 1) ? $clog2(TAIL) : 1;

  localparam logic [LW-1:0] LEAD_END = LW'(LEAD - 1);
  localparam logic [WW-1:0] WORD_END = WW'(WIDTH - 1);
  localparam logic [TW-1:0] TAIL_END = TW'(TAIL - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LEAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_TAIL  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_d;
  logic [LW-1:0]    lcnt;
  logic [LW-1:0]    lcnt_d;
  logic [WW-1:0]    wcnt;
  logic [WW-1:0]    wcnt_d;
  logic [TW-1:0]    tcnt;
  logic [TW-1:0]    tcnt_d;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_d;
  logic [WIDTH-1:0] sh_next;
  logic             last_bit;
  logic             xfer;
  logic             bit_d;
  logic             o_i_d;
  logic             o_t_d;

  assign last_bit  = (state == S_SHIFT) && (wcnt == WORD_END);
  assign DIN_READY = ((state == S_IDLE) || last_bit) && !ABORT;
  assign xfer      = DIN_VALID && DIN_READY;
  assign BUSY      = (state != S_IDLE);

  // The outgoing bit always sits at one end of the shift register.
  assign sh_next = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0}
                             : {1'b0, sh[WIDTH-1:1]};

  always_comb begin
    state_d = state;
    lcnt_d  = lcnt;
    wcnt_d  = wcnt;
    tcnt_d  = tcnt;
    sh_d    = sh;
    unique case (1'b1)
      state == S_IDLE: begin
        if (xfer) begin
          state_d = S_LEAD;
          sh_d    = DIN;
        end
      end
      state == S_LEAD: begin
        if (ABORT) begin
          state_d = S_TAIL;
          lcnt_d  = '0;
        end else if (lcnt == LEAD_END) begin
          state_d = S_SHIFT;
          lcnt_d  = '0;
        end else begin
          lcnt_d = lcnt + LW'(1);
        end
      end
      state == S_SHIFT: begin
        if (ABORT) begin
          state_d = S_TAIL;
          wcnt_d  = '0;
        end else if (wcnt == WORD_END) begin
          wcnt_d = '0;
          if (xfer) begin
            sh_d = DIN;
          end else begin
            state_d = S_TAIL;
          end
        end else begin
          wcnt_d = wcnt + WW'(1);
          sh_d   = sh_next;
        end
      end
      state == S_TAIL: begin
        if (tcnt == TAIL_END) begin
          state_d = S_IDLE;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state so the pad never sees a
  // combinational path from the inputs.
  assign bit_d = MSB_FIRST ? sh_d[WIDTH-1] : sh_d[0];
  assign o_i_d = (state_d == S_SHIFT) ? bit_d : 1'b1;
  assign o_t_d = (state_d == S_IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      lcnt  <= '0;
      wcnt  <= '0;
      tcnt  <= '0;
      sh    <= '0;
      O_I   <= 1'b1;
      O_T   <= 1'b1;
    end else begin
      state <= state_d;
      lcnt  <= lcnt_d;
      wcnt  <= wcnt_d;
      tcnt  <= tcnt_d;
      sh    <= sh_d;
      O_I   <= o_i_d;
      O_T   <= o_t_d;
    end
  end

endmodule
